sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH (default 8).
REQ-003 Parameter AF_THR, 6, almost-full threshold; valid range 1..DEPTH-1.
REQ-004 Parameter AE_THR, 2, almost-empty threshold; valid range 1..DEPTH-1.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous and active-high.
REQ-007 WR_INC  in  1  write request.
REQ-008 WR_DATA  in  DATA_WIDTH  write word.
REQ-009 RD_INC  in  1  read request.
REQ-010 CLR_ERR  in  1  clears sticky OVF/UDF.
REQ-011 RD_DATA  out  DATA_WIDTH  registered read word.
REQ-012 RD_VALID  out  1  one-cycle pulse marking RD_DATA as new.
REQ-013 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out  1 each  status flags.
REQ-014 COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 OVF, UDF  out  1 each  sticky overflow/underflow flags.

Function
REQ-016 Write accepted when WR_INC=1 and (FULL=0 or read accepted same cycle); word stored at write pointer, pointer +1 mod DEPTH.
REQ-017 Read accepted when RD_INC=1 and EMPTY=0; word at read pointer loaded into RD_DATA next edge, RD_VALID=1 for that one cycle, pointer +1 mod DEPTH.
REQ-018 Read latency exactly 1 cycle from accepted RD_INC edge to RD_VALID/RD_DATA.
REQ-019 RD_DATA holds last read word until next accepted read; it never changes without RD_VALID.
REQ-020 Pointers ADDR_WIDTH+1 bits with wrap bit; FULL = addresses equal and wrap bits differ; EMPTY = pointers fully equal.
REQ-021 COUNT: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-022 ALMOST_FULL = (COUNT >= AF_THR); ALMOST_EMPTY = (COUNT <= AE_THR); all flags are registered, consistent with COUNT in the same cycle.
REQ-023 WR_INC while FULL and no read accepted: write dropped, memory/pointers unchanged, OVF set next cycle.
REQ-024 RD_INC while EMPTY: read ignored, RD_VALID stays 0, UDF set next cycle; no write-to-read bypass.
REQ-025 Simultaneous WR_INC and RD_INC at FULL: both accepted, COUNT stays DEPTH.
REQ-026 Simultaneous WR_INC and RD_INC at EMPTY: write accepted, read ignored, UDF set, COUNT becomes 1.
REQ-027 CLR_ERR=1 clears OVF/UDF next cycle; a new error in the same cycle wins (flag stays/becomes 1).

Reset
REQ-028 RST=1 at an edge: pointers, COUNT, RD_DATA, RD_VALID, OVF, UDF, FULL, ALMOST_FULL to 0; EMPTY, ALMOST_EMPTY to 1.
REQ-029 Reset overrides all requests in the same cycle; memory contents are not cleared and are unreachable until rewritten.
REQ-030 Reset mid-operation discards stored data; first post-reset read returns data written after reset.

Structure
REQ-031 Shared package/header holds default DATA_WIDTH, ADDR_WIDTH, AF_THR, AE_THR constants used by system-level instantiation.
REQ-032 Storage in one sub-module fifo_dp_ram (synchronous write, combinational read by address); pointers, flags, count in sync_fifo_ctrl.

Verification
REQ-033 Reset, write 0x11..0x18 (8 words) -> FULL=1 after 8th, COUNT=8, ALMOST_FULL=1 from COUNT=6; 9th write 0xFF dropped, OVF=1.
REQ-034 From full, read 8 -> RD_DATA 0x11..0x18 in order, each with RD_VALID 1 cycle after RD_INC; EMPTY=1, COUNT=0.
REQ-035 Read while empty -> RD_VALID=0, RD_DATA unchanged, UDF=1; CLR_ERR pulse -> UDF=0 next cycle.
REQ-036 Fill to 8, then WR_INC+RD_INC same cycle with 0xA5 -> read returns 0x11, COUNT stays 8, 0xA5 read out 8th later; 20 continuous writes+reads exercise pointer wrap.
REQ-037 Write 3 words, assert RST with WR_INC=1 -> all outputs at reset values next cycle; write 0x5A, read -> RD_DATA=0x5A.

Source files
------------

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared defaults for the synchronous FIFO controller, used by system-level instantiation.
package sync_fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEF_AF_THR     = 6;
  localparam int unsigned DEF_AE_THR     = 2;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO controller (slave).
interface sync_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);

  logic                  wr_inc;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_inc;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  ovf;
  logic                  udf;

  modport master (
    output wr_inc, wr_data, rd_inc, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  wr_inc, wr_data, rd_inc, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, ovf, udf
  );

endinterface

// File: rtl/fifo_dp_ram.sv
// FIFO storage: synchronous write port, combinational read by address, no reset.
module fifo_dp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, registered flags, sticky errors, read register.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_THR     = DEF_AF_THR,
  parameter int unsigned AE_THR     = DEF_AE_THR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned Cw = ADDR_WIDTH + 1;
  localparam logic [Cw-1:0] CntOne = Cw'(1);
  localparam logic [Cw-1:0] AfLim  = Cw'(AF_THR);
  localparam logic [Cw-1:0] AeLim  = Cw'(AE_THR);

  logic [Cw-1:0]         r_wr_ptr, r_rd_ptr, r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_udf;

  logic                  w_wr_acc, w_rd_acc;
  logic [Cw-1:0]         w_wr_ptr_d, w_rd_ptr_d, w_count_d;
  logic                  w_full_d, w_empty_d;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
  assign w_rd_acc = bus.rd_inc && !r_empty;
  assign w_wr_acc = bus.wr_inc && (!r_full || w_rd_acc);

  assign w_wr_ptr_d = w_wr_acc ? r_wr_ptr + CntOne : r_wr_ptr;
  assign w_rd_ptr_d = w_rd_acc ? r_rd_ptr + CntOne : r_rd_ptr;

  always_comb begin
    w_count_d = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_d = r_count + CntOne;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_d = r_count - CntOne;
    end
  end

  assign w_full_d  = (w_wr_ptr_d[ADDR_WIDTH-1:0] == w_rd_ptr_d[ADDR_WIDTH-1:0]) &&
                     (w_wr_ptr_d[ADDR_WIDTH] != w_rd_ptr_d[ADDR_WIDTH]);
  assign w_empty_d = (w_wr_ptr_d == w_rd_ptr_d);

  fifo_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_acc && !i_rst),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= 1'b0;
      r_ae       <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_d;
      r_rd_ptr   <= w_rd_ptr_d;
      r_count    <= w_count_d;
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_ram_rdata;
      end
      r_full  <= w_full_d;
      r_empty <= w_empty_d;
      r_af    <= (w_count_d >= AfLim);
      r_ae    <= (w_count_d <= AeLim);
      // A fresh error in the clearing cycle keeps its flag set.
      r_ovf   <= (bus.wr_inc && r_full && !w_rd_acc) || (r_ovf && !bus.clr_err);
      r_udf   <= (bus.rd_inc && r_empty) || (r_udf && !bus.clr_err);
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.ovf          = r_ovf;
  assign bus.udf          = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: fill/drain, errors, simultaneous access, wrap, reset.
module tb_sync_fifo_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  sync_fifo_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .AF_THR     (6),
    .AE_THR     (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it; inputs are changed only after this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_inc  = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_inc  = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count actual=%0d required=0", bus.count); end
    n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty actual=%b required=1", bus.empty); end
    n_vec++; if (bus.almost_empty !== 1'b1) begin n_err++; $display("FAIL rst_ae actual=%b required=1", bus.almost_empty); end
    n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL rst_full actual=%b required=0", bus.full); end
    n_vec++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL rst_af actual=%b required=0", bus.almost_full); end
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid actual=%b required=0", bus.rd_valid); end
    n_vec++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data actual=%h required=00", bus.rd_data); end
    n_vec++; if ({bus.ovf, bus.udf} !== 2'b00) begin n_err++; $display("FAIL rst_err_flags actual=%b required=00", {bus.ovf, bus.udf}); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      bus.wr_inc  = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      step();
      n_vec++; if (bus.count !== 4'(i)) begin n_err++; $display("FAIL fill_count[%0d] actual=%0d required=%0d", i, bus.count, i); end
      n_vec++; if (bus.almost_full !== (i >= 6)) begin n_err++; $display("FAIL fill_af[%0d] actual=%b required=%b", i, bus.almost_full, i >= 6); end
      n_vec++; if (bus.almost_empty !== (i <= 2)) begin n_err++; $display("FAIL fill_ae[%0d] actual=%b required=%b", i, bus.almost_empty, i <= 2); end
      n_vec++; if (bus.full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d] actual=%b required=%b", i, bus.full, i == 8); end
      n_vec++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] actual=%b required=0", i, bus.empty); end
    end
    bus.wr_data = 8'hFF;
    step();
    bus.wr_inc = 1'b0;
    n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set actual=%b required=1", bus.ovf); end
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL ovf_count actual=%0d required=8", bus.count); end
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full actual=%b required=1", bus.full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      bus.rd_inc = 1'b1;
      step();
      n_vec++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] actual=%b required=1", i, bus.rd_valid); end
      n_vec++; if (bus.rd_data !== 8'(8'h11 + i)) begin n_err++; $display("FAIL drain_data[%0d] actual=%h required=%h", i, bus.rd_data, 8'(8'h11 + i)); end
      n_vec++; if (bus.count !== 4'(7 - i)) begin n_err++; $display("FAIL drain_count[%0d] actual=%0d required=%0d", i, bus.count, 7 - i); end
    end
    bus.rd_inc = 1'b0;
    step();
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid_drop actual=%b required=0", bus.rd_valid); end
    n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty actual=%b required=1", bus.empty); end
    n_vec++; if (bus.rd_data !== 8'h18) begin n_err++; $display("FAIL drain_hold actual=%h required=18", bus.rd_data); end
  endtask

  task automatic test_underflow();
    bus.rd_inc = 1'b1;
    step();
    bus.rd_inc = 1'b0;
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid actual=%b required=0", bus.rd_valid); end
    n_vec++; if (bus.rd_data !== 8'h18) begin n_err++; $display("FAIL udf_data actual=%h required=18", bus.rd_data); end
    n_vec++; if (bus.udf !== 1'b1) begin n_err++; $display("FAIL udf_set actual=%b required=1", bus.udf); end
    // Clear together with a new underflow: the new error wins.
    bus.clr_err = 1'b1;
    bus.rd_inc  = 1'b1;
    step();
    bus.rd_inc  = 1'b0;
    n_vec++; if (bus.udf !== 1'b1) begin n_err++; $display("FAIL udf_clr_race actual=%b required=1", bus.udf); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr actual=%b required=0", bus.ovf); end
    step();
    bus.clr_err = 1'b0;
    n_vec++; if (bus.udf !== 1'b0) begin n_err++; $display("FAIL udf_clr actual=%b required=0", bus.udf); end
    step();
    n_vec++; if (bus.udf !== 1'b0) begin n_err++; $display("FAIL udf_stay_clr actual=%b required=0", bus.udf); end
  endtask

  task automatic test_simul_full();
    for (int i = 1; i <= 8; i++) begin
      bus.wr_inc  = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      step();
    end
    bus.wr_data = 8'hA5;
    bus.rd_inc  = 1'b1;
    step();
    bus.wr_inc  = 1'b0;
    n_vec++; if (bus.rd_data !== 8'h11) begin n_err++; $display("FAIL sim_full_data actual=%h required=11", bus.rd_data); end
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL sim_full_count actual=%0d required=8", bus.count); end
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL sim_full_full actual=%b required=1", bus.full); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL sim_full_ovf actual=%b required=0", bus.ovf); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 7) ? 8'hA5 : 8'(8'h12 + i);
      step();
      n_vec++; if (bus.rd_data !== exp_d) begin n_err++; $display("FAIL sim_full_drain[%0d] actual=%h required=%h", i, bus.rd_data, exp_d); end
    end
    bus.rd_inc = 1'b0;
    step();
    n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL sim_full_empty actual=%b required=1", bus.empty); end
  endtask

  task automatic test_simul_empty();
    bus.wr_inc  = 1'b1;
    bus.wr_data = 8'h77;
    bus.rd_inc  = 1'b1;
    step();
    bus.wr_inc  = 1'b0;
    bus.rd_inc  = 1'b0;
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL sim_empty_count actual=%0d required=1", bus.count); end
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL sim_empty_valid actual=%b required=0", bus.rd_valid); end
    n_vec++; if (bus.udf !== 1'b1) begin n_err++; $display("FAIL sim_empty_udf actual=%b required=1", bus.udf); end
    bus.rd_inc  = 1'b1;
    bus.clr_err = 1'b1;
    step();
    bus.rd_inc  = 1'b0;
    bus.clr_err = 1'b0;
    n_vec++; if (bus.rd_data !== 8'h77) begin n_err++; $display("FAIL sim_empty_data actual=%h required=77", bus.rd_data); end
    n_vec++; if (bus.udf !== 1'b0) begin n_err++; $display("FAIL sim_empty_clr actual=%b required=0", bus.udf); end
  endtask

  task automatic test_back_to_back();
    bus.wr_inc  = 1'b1;
    bus.wr_data = 8'h30;
    step();
    bus.rd_inc  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      bus.wr_data = 8'(8'h30 + i);
      step();
      n_vec++; if (bus.rd_data !== 8'(8'h30 + i - 1)) begin n_err++; $display("FAIL b2b_data[%0d] actual=%h required=%h", i, bus.rd_data, 8'(8'h30 + i - 1)); end
      n_vec++; if (bus.count !== 4'd1 || bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_state[%0d] actual=%0d/%b required=1/1", i, bus.count, bus.rd_valid); end
    end
    bus.wr_inc = 1'b0;
    step();
    bus.rd_inc = 1'b0;
    n_vec++; if (bus.rd_data !== 8'h44) begin n_err++; $display("FAIL b2b_last actual=%h required=44", bus.rd_data); end
    n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty actual=%b required=1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.wr_inc  = 1'b1;
      bus.wr_data = 8'(8'hC0 + i);
      step();
    end
    bus.wr_data = 8'hEE;
    bus.rd_inc  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.wr_inc = 1'b0;
    bus.rd_inc = 1'b0;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL mid_rst_count actual=%0d required=0", bus.count); end
    n_vec++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty actual=%b%b required=11", bus.empty, bus.almost_empty); end
    n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_rd actual=%b/%h required=0/00", bus.rd_valid, bus.rd_data); end
    n_vec++; if ({bus.full, bus.almost_full, bus.ovf, bus.udf} !== 4'b0000) begin n_err++; $display("FAIL mid_rst_flags actual=%b required=0000", {bus.full, bus.almost_full, bus.ovf, bus.udf}); end
    bus.wr_inc  = 1'b1;
    bus.wr_data = 8'h5A;
    step();
    bus.wr_inc = 1'b0;
    bus.rd_inc = 1'b1;
    step();
    bus.rd_inc = 1'b0;
    n_vec++; if (bus.rd_data !== 8'h5A || bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL mid_rst_read actual=%h/%b required=5a/1", bus.rd_data, bus.rd_valid); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL mid_rst_final_count actual=%0d required=0", bus.count); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_simul_full();
    test_simul_empty();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
